alu_rs: RTL

- Reservation station and issue scheduler in front of the ALU.
- Buffers decoded ALU/branch/jump instructions from the decoder and tracks pending source operands by ROB tag.
- Snoops both result broadcast buses (ALU and LSB) to capture pending operands.
- Each cycle issues at most one fully-ready entry to the ALU's inst_valid interface; provides back-pressure to the decoder.

---
 rtl/alu_rs_pkg.sv | 29 ++
 rtl/rs_lowest_set.sv | 25 ++
 rtl/alu_rs.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths and record types for the ALU reservation station.
// Anything that includes this package sees the same opcode/data/tag geometry.
package alu_rs_pkg;

  localparam int OPCODE_WID = 7;
  localparam int FUNC3_WID  = 3;
  localparam int DATA_WID   = 32;
  localparam int ADDR_WID   = 32;
  localparam int ROB_ID_WID = 4;
  localparam int RS_ENTRIES = 8;
  localparam int RS_ID_WID  = 3;

  // Everything about an instruction that is not a source operand.
  typedef struct packed {
    logic [OPCODE_WID-1:0] opcode;
    logic [FUNC3_WID-1:0]  func3;
    logic                  func1;
    logic [DATA_WID-1:0]   imm;
    logic [DATA_WID-1:0]   off;
    logic [ADDR_WID-1:0]   pc;
  } rs_inst_t;

  // One source operand: still waiting on a producer, or holding its value.
  typedef struct packed {
    logic                dep;
    logic [DATA_WID-1:0] val;
  } rs_opnd_t;

endpackage

// File: rtl/rs_lowest_set.sv
// Priority encoder: index of the lowest set bit of i_vec, plus a found flag.
// Used for both the free-slot search and the ready-slot search.
module rs_lowest_set #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every output a default first, so no latch can be inferred.
    o_found = 1'b0;
    o_idx   = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: buffers dispatched instructions,
// snoops the ALU/LSB result buses for pending operands, issues one ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = RS_ENTRIES,
  parameter int RS_ID_W  = RS_ID_WID,
  parameter int ROB_ID_W = ROB_ID_WID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,

  input  logic                  in_valid,
  input  logic [OPCODE_WID-1:0] in_opcode,
  input  logic [FUNC3_WID-1:0]  in_func3,
  input  logic                  in_func1,
  input  logic [DATA_WID-1:0]   in_imm,
  input  logic [DATA_WID-1:0]   in_off,
  input  logic [ADDR_WID-1:0]   in_pc,
  input  logic [ROB_ID_W-1:0]   in_rob_target,
  input  logic [DATA_WID-1:0]   in_rs1_val,
  input  logic [DATA_WID-1:0]   in_rs2_val,
  input  logic                  in_rs1_dep,
  input  logic                  in_rs2_dep,
  input  logic [ROB_ID_W-1:0]   in_rs1_tag,
  input  logic [ROB_ID_W-1:0]   in_rs2_tag,
  output logic                  full,

  input  logic                  alu_res_valid,
  input  logic [ROB_ID_W-1:0]   alu_res_tag,
  input  logic [DATA_WID-1:0]   alu_res_data,
  input  logic                  lsb_res_valid,
  input  logic [ROB_ID_W-1:0]   lsb_res_tag,
  input  logic [DATA_WID-1:0]   lsb_res_data,

  output logic                  out_valid,
  output logic [OPCODE_WID-1:0] out_opcode,
  output logic [FUNC3_WID-1:0]  out_func3,
  output logic                  out_func1,
  output logic [DATA_WID-1:0]   out_data1,
  output logic [DATA_WID-1:0]   out_data2,
  output logic [DATA_WID-1:0]   out_imm,
  output logic [DATA_WID-1:0]   out_off,
  output logic [ADDR_WID-1:0]   out_pc,
  output logic [ROB_ID_W-1:0]   out_rob_target
);

  logic [RS_SIZE-1:0]  r_busy;
  logic [RS_SIZE-1:0]  r_dep1;
  logic [RS_SIZE-1:0]  r_dep2;
  logic [ROB_ID_W-1:0] r_tag1 [RS_SIZE];
  logic [ROB_ID_W-1:0] r_tag2 [RS_SIZE];
  logic [ROB_ID_W-1:0] r_rob  [RS_SIZE];
  logic [DATA_WID-1:0] r_val1 [RS_SIZE];
  logic [DATA_WID-1:0] r_val2 [RS_SIZE];
  rs_inst_t            r_inst [RS_SIZE];

  logic [RS_SIZE-1:0]  w_ready;
  logic                w_free_found;
  logic [RS_ID_W-1:0]  w_free_idx;
  logic                w_iss_found;
  logic [RS_ID_W-1:0]  w_iss_idx;
  logic                w_dispatch;
  rs_inst_t            w_in_inst;
  rs_opnd_t            w_in1;
  rs_opnd_t            w_in2;
  rs_opnd_t            w_nxt1 [RS_SIZE];
  rs_opnd_t            w_nxt2 [RS_SIZE];

  // Capture a broadcast for a pending operand; the ALU bus wins if both buses match.
  function automatic rs_opnd_t snoop(input rs_opnd_t cur, input logic [ROB_ID_W-1:0] tag);
    snoop = cur;
    if (cur.dep && alu_res_valid && alu_res_tag == tag) begin
      snoop = '{dep: 1'b0, val: alu_res_data};
    end else if (cur.dep && lsb_res_valid && lsb_res_tag == tag) begin
      snoop = '{dep: 1'b0, val: lsb_res_data};
    end
  endfunction

  assign w_ready    = r_busy & ~r_dep1 & ~r_dep2;
  assign full       = &r_busy;
  assign w_dispatch = in_valid & w_free_found;

  rs_lowest_set #(.N(RS_SIZE), .W(RS_ID_W)) u_free_sel (
    .i_vec   (~r_busy),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_lowest_set #(.N(RS_SIZE), .W(RS_ID_W)) u_issue_sel (
    .i_vec   (w_ready),
    .o_found (w_iss_found),
    .o_idx   (w_iss_idx)
  );

  always_comb begin
    w_in_inst = '{opcode: in_opcode, func3: in_func3, func1: in_func1,
                  imm: in_imm, off: in_off, pc: in_pc};
    w_in1 = snoop('{dep: in_rs1_dep, val: in_rs1_val}, in_rs1_tag);
    w_in2 = snoop('{dep: in_rs2_dep, val: in_rs2_val}, in_rs2_tag);
    for (int i = 0; i < RS_SIZE; i++) begin
      w_nxt1[i] = snoop('{dep: r_dep1[i], val: r_val1[i]}, r_tag1[i]);
      w_nxt2[i] = snoop('{dep: r_dep2[i], val: r_val2[i]}, r_tag2[i]);
    end
  end

  // Control state: occupancy, operand-pending flags and the issue register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy         <= '0;
      r_dep1         <= '0;
      r_dep2         <= '0;
      out_valid      <= 1'b0;
      out_opcode     <= '0;
      out_func3      <= '0;
      out_func1      <= 1'b0;
      out_data1      <= '0;
      out_data2      <= '0;
      out_imm        <= '0;
      out_off        <= '0;
      out_pc         <= '0;
      out_rob_target <= '0;
    end else if (rollback) begin
      r_busy    <= '0;
      out_valid <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_dep1[i] <= w_nxt1[i].dep;
        r_dep2[i] <= w_nxt2[i].dep;
      end
      out_valid <= w_iss_found;
      if (w_iss_found) begin
        r_busy[w_iss_idx] <= 1'b0;
        out_opcode        <= r_inst[w_iss_idx].opcode;
        out_func3         <= r_inst[w_iss_idx].func3;
        out_func1         <= r_inst[w_iss_idx].func1;
        out_imm           <= r_inst[w_iss_idx].imm;
        out_off           <= r_inst[w_iss_idx].off;
        out_pc            <= r_inst[w_iss_idx].pc;
        out_data1         <= r_val1[w_iss_idx];
        out_data2         <= r_val2[w_iss_idx];
        out_rob_target    <= r_rob[w_iss_idx];
      end
      // The free slot is never the issuing slot, so these writes cannot collide.
      if (w_dispatch) begin
        r_busy[w_free_idx] <= 1'b1;
        r_dep1[w_free_idx] <= w_in1.dep;
        r_dep2[w_free_idx] <= w_in2.dep;
      end
    end
  end

  // NOTE: entry payload carries no reset; busy and dep gate every use, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_val1[i] <= w_nxt1[i].val;
        r_val2[i] <= w_nxt2[i].val;
      end
      if (w_dispatch) begin
        r_inst[w_free_idx] <= w_in_inst;
        r_rob[w_free_idx]  <= in_rob_target;
        r_tag1[w_free_idx] <= in_rs1_tag;
        r_tag2[w_free_idx] <= in_rs2_tag;
        r_val1[w_free_idx] <= w_in1.val;
        r_val2[w_free_idx] <= w_in2.val;
      end
    end
  end

endmodule
